// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and encodings.
// Imported by the hazard sequencer and its helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN,
    LU,
    SLEEP,
    TRAP
  } ctrl_state_t;

  localparam logic [1:0] INSTR_PASS   = 2'b00;
  localparam logic [1:0] INSTR_REPLAY = 2'b01;
  localparam logic [1:0] INSTR_FLUSH  = 2'b10;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_TVEC = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID sources and the EX load.
// Purely combinational; x0 never creates a hazard.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_use_rs1,
  input  logic              i_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_memRead,
  output logic              o_hazard
);

  logic w_rd_nz;
  logic w_m1;
  logic w_m2;

  assign w_rd_nz  = |i_ex_rd;
  assign w_m1     = i_use_rs1 & (i_rs1 == i_ex_rd);
  assign w_m2     = i_use_rs2 & (i_rs2 == i_ex_rd);
  assign o_hazard = i_ex_memRead & w_rd_nz & (w_m1 | w_m2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID and ID/EX registers.
// Priority: bus stall > interrupt > redirect > load-use > WFI.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_stall,
  input  logic              dm_stall,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_isWFI,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memRead,
  input  logic              ex_redirect,
  input  logic              irq_pending,
  output logic [1:0]        busStall,
  output logic [1:0]        instr_sel,
  output logic              loadUse,
  output logic              isWFI,
  output logic              interrupt,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              bubble_EX,
  output logic [PERF_W-1:0] stall_cnt
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [PERF_W-1:0] r_cnt;
  logic              w_cnt_inc;
  logic              w_hazard;
  logic              w_bus;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_lud (
    .i_rs1        (id_rs1),
    .i_rs2        (id_rs2),
    .i_use_rs1    (id_use_rs1),
    .i_use_rs2    (id_use_rs2),
    .i_ex_rd      (ex_rd),
    .i_ex_memRead (ex_memRead),
    .o_hazard     (w_hazard)
  );

  assign w_bus     = im_stall | dm_stall;
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_inc)
        r_cnt <= r_cnt + PERF_W'(1);
    end
  end

  always_comb begin
    busStall  = {dm_stall, im_stall};
    instr_sel = INSTR_PASS;
    loadUse   = 1'b0;
    isWFI     = (r_state == SLEEP);
    interrupt = 1'b0;
    pc_write  = 1'b1;
    pc_sel    = PC_SEQ;
    bubble_EX = 1'b0;
    w_next    = r_state;
    w_cnt_inc = 1'b0;

    if (w_bus) begin
      // Frozen: pending redirect/irq are simply not acted on yet.
      pc_write  = 1'b0;
      w_cnt_inc = 1'b1;
    end else begin
      unique case (r_state)
        RUN, LU: begin
          if (irq_pending) begin
            interrupt = 1'b1;
            pc_sel    = PC_TVEC;
            instr_sel = INSTR_FLUSH;
            bubble_EX = 1'b1;
            w_next    = TRAP;
          end else if (ex_redirect) begin
            pc_sel    = PC_TGT;
            instr_sel = INSTR_FLUSH;
            bubble_EX = 1'b1;
            w_next    = TRAP;
          end else if (r_state == LU) begin
            instr_sel = INSTR_REPLAY;
            w_next    = RUN;
          end else if (w_hazard) begin
            loadUse   = 1'b1;
            pc_write  = 1'b0;
            bubble_EX = 1'b1;
            w_cnt_inc = 1'b1;
            w_next    = LU;
          end else if (id_isWFI) begin
            pc_write  = 1'b0;
            w_next    = SLEEP;
          end
        end
        SLEEP: begin
          bubble_EX = 1'b1;
          if (irq_pending) begin
            interrupt = 1'b1;
            pc_sel    = PC_TVEC;
            instr_sel = INSTR_FLUSH;
            w_next    = TRAP;
          end else begin
            pc_write  = 1'b0;
            w_cnt_inc = 1'b1;
          end
        end
        TRAP: begin
          instr_sel = INSTR_FLUSH;
          w_next    = RUN;
        end
        default: w_next = RUN;
      endcase
    end
  end

endmodule
